// File: rtl/airfield_pkg.sv
// Shared types and constants for the runway sequencer: runway state encoding,
// LED bit positions, and a small elaboration-time helper.
package airfield_pkg;

    typedef enum logic [2:0] {
        CLOSED   = 3'd0,
        READY    = 3'd1,
        RESERVED = 3'd2,
        BUSY     = 3'd3,
        CLEARING = 3'd4
    } rwy_state_t;

    localparam int GREEN  = 0;
    localparam int RED    = 1;
    localparam int YELLOW = 2;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/airfield_runway_fsm.sv
// One runway: state machine, shared RESERVED/CLEARING dwell timer and LED decode.
// State and LEDs update on the same edge (LEDs decoded from next state); no backpressure.
module airfield_runway_fsm
    import airfield_pkg::*;
#(
    parameter int CLEAR_CYCLES = 16,
    parameter int RESV_TIMEOUT = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wx_ok,
    input  logic       occupied,
    input  logic       grant,
    input  logic       emergency,
    output rwy_state_t state,
    output logic [2:0] led
);

    localparam int TMAX = max_int(CLEAR_CYCLES, RESV_TIMEOUT);
    localparam int TW   = $clog2(TMAX + 1);
    localparam logic [TW-1:0] T_CLEAR_END = TW'(CLEAR_CYCLES - 1);
    localparam logic [TW-1:0] T_RESV_END  = TW'(RESV_TIMEOUT - 1);
    localparam logic [TW-1:0] T_SAT       = TW'(TMAX);
    localparam logic [2:0]    LED_RED     = 3'b1 << RED;

    rwy_state_t    state_nxt;
    logic [TW-1:0] timer;
    logic [2:0]    led_nxt;

    always_comb begin
        state_nxt = state;
        led_nxt   = '0;
        case (state)
            CLOSED: begin
                if (occupied)   state_nxt = BUSY;
                else if (wx_ok) state_nxt = READY;
            end
            READY: begin
                if (occupied)    state_nxt = BUSY;
                else if (grant)  state_nxt = RESERVED;
                else if (!wx_ok) state_nxt = CLOSED;
            end
            RESERVED: begin
                if (occupied)                 state_nxt = BUSY;
                else if (!wx_ok)              state_nxt = CLOSED;
                else if (timer == T_RESV_END) state_nxt = READY;
            end
            BUSY: begin
                // Weather is deliberately ignored while a plane is on the runway.
                if (!occupied) state_nxt = CLEARING;
            end
            CLEARING: begin
                if (occupied)                  state_nxt = BUSY;
                else if (timer == T_CLEAR_END) state_nxt = wx_ok ? READY : CLOSED;
            end
            default: state_nxt = CLOSED;
        endcase

        case (state_nxt)
            READY: begin
                led_nxt[GREEN]  = !emergency;
                led_nxt[YELLOW] = emergency;
            end
            CLEARING: begin
                led_nxt[RED]    = !emergency;
                led_nxt[YELLOW] = emergency;
            end
            default: led_nxt[RED] = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= CLOSED;
            timer <= '0;
            led   <= LED_RED;
        end else begin
            state <= state_nxt;
            led   <= led_nxt;
            if (state_nxt != state)
                timer <= '0;
            else if (timer != T_SAT)
                timer <= timer + 1'b1;
        end
    end

endmodule

// File: rtl/airfield_runway_sequencer.sv
// Airfield controller top: weather debounce, emergency compare, runway grant arbiter, N runway FSMs.
// All outputs registered, one-cycle latency from inputs; req is level and simply waits while no runway is READY.
module airfield_runway_sequencer
    import airfield_pkg::*;
#(
    parameter int N_RUNWAYS    = 2,
    parameter int PAX_W        = 7,
    parameter int PAX_EMERG    = 60,
    parameter int WX_DEBOUNCE  = 4,
    parameter int CLEAR_CYCLES = 16,
    parameter int RESV_TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 weather,
    input  logic [PAX_W-1:0]     passengers,
    input  logic [N_RUNWAYS-1:0] occupied,
    input  logic                 req,
    output logic [N_RUNWAYS-1:0] grant,
    output logic                 emergency,
    output logic                 wx_ok,
    output logic [N_RUNWAYS-1:0] led_green,
    output logic [N_RUNWAYS-1:0] led_red,
    output logic [N_RUNWAYS-1:0] led_yellow
);

    localparam int WXW = $clog2(WX_DEBOUNCE + 1);

    logic [WXW-1:0]       wx_cnt;
    logic                 emergency_nxt;
    logic [N_RUNWAYS-1:0] ready;
    logic [N_RUNWAYS-1:0] grant_nxt;
    logic                 found;
    rwy_state_t           state [N_RUNWAYS];
    logic [2:0]           led   [N_RUNWAYS];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wx_ok  <= 1'b0;
            wx_cnt <= '0;
        end else if (weather != wx_ok) begin
            if (wx_cnt == WXW'(WX_DEBOUNCE - 1)) begin
                wx_ok  <= weather;
                wx_cnt <= '0;
            end else begin
                wx_cnt <= wx_cnt + 1'b1;
            end
        end else begin
            wx_cnt <= '0;
        end
    end

    // LEDs use the same compare result so they switch colour on the edge emergency changes.
    assign emergency_nxt = 32'(passengers) >= PAX_EMERG;

    // Lowest-index READY runway wins; a cycle with a live grant blocks the next one.
    always_comb begin
        grant_nxt = '0;
        found     = 1'b0;
        if (req && (grant == '0)) begin
            for (int i = 0; i < N_RUNWAYS; i++) begin
                if (!found && ready[i]) begin
                    grant_nxt[i] = 1'b1;
                    found        = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            grant     <= '0;
            emergency <= 1'b0;
        end else begin
            grant     <= grant_nxt;
            emergency <= emergency_nxt;
        end
    end

    for (genvar r = 0; r < N_RUNWAYS; r++) begin : g_rwy
        airfield_runway_fsm #(
            .CLEAR_CYCLES (CLEAR_CYCLES),
            .RESV_TIMEOUT (RESV_TIMEOUT)
        ) u_fsm (
            .clk       (clk),
            .rst_n     (rst_n),
            .wx_ok     (wx_ok),
            .occupied  (occupied[r]),
            .grant     (grant_nxt[r]),
            .emergency (emergency_nxt),
            .state     (state[r]),
            .led       (led[r])
        );

        assign ready[r]      = (state[r] == READY);
        assign led_green[r]  = led[r][GREEN];
        assign led_red[r]    = led[r][RED];
        assign led_yellow[r] = led[r][YELLOW];
    end

endmodule

// File: tb/tb_airfield_runway_sequencer.sv
// Scoreboarded bench: a cycle-level reference model predicts every output snapshot,
// a monitor compares the DUT outputs one cycle at a time.
module tb_airfield_runway_sequencer;

    localparam int N    = 2;
    localparam int PAXW = 7;
    localparam int PAXE = 60;
    localparam int WXD  = 4;
    localparam int CLR  = 16;
    localparam int RTO  = 64;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            weather;
    logic [PAXW-1:0] passengers;
    logic [N-1:0]    occupied;
    logic            req;
    logic [N-1:0]    grant, led_green, led_red, led_yellow;
    logic            emergency, wx_ok;

    airfield_runway_sequencer #(
        .N_RUNWAYS    (N),
        .PAX_W        (PAXW),
        .PAX_EMERG    (PAXE),
        .WX_DEBOUNCE  (WXD),
        .CLEAR_CYCLES (CLR),
        .RESV_TIMEOUT (RTO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .weather    (weather),
        .passengers (passengers),
        .occupied   (occupied),
        .req        (req),
        .grant      (grant),
        .emergency  (emergency),
        .wx_ok      (wx_ok),
        .led_green  (led_green),
        .led_red    (led_red),
        .led_yellow (led_yellow)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [N-1:0] grant;
        logic [N-1:0] green;
        logic [N-1:0] red;
        logic [N-1:0] yellow;
        logic         emergency;
        logic         wx_ok;
    } obs_t;

    typedef enum int {S_CLOSED, S_READY, S_HELD, S_BUSY, S_CLEAR} mst_t;

    obs_t exp_q[$];
    int   checks = 0;
    int   passes = 0;
    int   cyc    = 0;

    // Reference model state: runway phase, cycles spent in that phase, filtered weather.
    mst_t m_st  [N];
    int   m_age [N];
    bit   m_wx;
    int   m_wx_run;
    bit   m_emerg;
    int   m_grant;

    function automatic mst_t next_phase(mst_t s, int age, bit wx, bit occ, bit gr);
        case (s)
            S_CLOSED: return occ ? S_BUSY : (wx ? S_READY : S_CLOSED);
            S_READY:  return occ ? S_BUSY : gr ? S_HELD : !wx ? S_CLOSED : S_READY;
            S_HELD:   return occ ? S_BUSY : !wx ? S_CLOSED : (age + 1 >= RTO) ? S_READY : S_HELD;
            S_BUSY:   return occ ? S_BUSY : S_CLEAR;
            default:  return occ ? S_BUSY : (age + 1 >= CLR) ? (wx ? S_READY : S_CLOSED) : S_CLEAR;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_st[i]  = S_CLOSED;
            m_age[i] = 0;
        end
        m_wx     = 1'b0;
        m_wx_run = 0;
        m_emerg  = 1'b0;
        m_grant  = -1;
    endtask

    // Advance the model across the coming edge using the inputs now on the pins.
    task automatic model_step();
        obs_t e;
        int   g;
        mst_t nx;
        if (!rst_n) begin
            model_reset();
        end else begin
            g = -1;
            if (req && m_grant < 0)
                for (int i = 0; i < N; i++)
                    if (g < 0 && m_st[i] == S_READY) g = i;
            for (int i = 0; i < N; i++) begin
                nx = next_phase(m_st[i], m_age[i], m_wx, occupied[i], g == i);
                m_age[i] = (nx == m_st[i]) ? m_age[i] + 1 : 0;
                m_st[i]  = nx;
            end
            if (weather != m_wx) begin
                m_wx_run++;
                if (m_wx_run >= WXD) begin
                    m_wx     = weather;
                    m_wx_run = 0;
                end
            end else begin
                m_wx_run = 0;
            end
            m_emerg = (int'(passengers) >= PAXE);
            m_grant = g;
        end
        e           = '0;
        e.emergency = m_emerg;
        e.wx_ok     = m_wx;
        if (m_grant >= 0) e.grant[m_grant] = 1'b1;
        for (int i = 0; i < N; i++) begin
            e.green[i]  = (m_st[i] == S_READY) && !m_emerg;
            e.yellow[i] = (m_st[i] == S_READY || m_st[i] == S_CLEAR) && m_emerg;
            e.red[i]    = !(e.green[i] || e.yellow[i]);
        end
        exp_q.push_back(e);
    endtask

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            model_step();
            @(negedge clk);
        end
    endtask

    initial begin : monitor
        obs_t e, a;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {grant, led_green, led_red, led_yellow, emergency, wx_ok};
                checks++;
                if (a === e)
                    passes++;
                else
                    $display("FAIL outputs cyc=%0d got grant=%b grn=%b red=%b yel=%b emg=%b wx=%b expected grant=%b grn=%b red=%b yel=%b emg=%b wx=%b",
                             cyc, a.grant, a.green, a.red, a.yellow, a.emergency, a.wx_ok,
                             e.grant, e.green, e.red, e.yellow, e.emergency, e.wx_ok);
            end
        end
    end

    initial begin : stimulus
        model_reset();
        rst_n = 1'b0; weather = 1'b0; passengers = '0; occupied = '0; req = 1'b0;
        tick(2);
        // Weather comes good, runways open.
        rst_n = 1'b1; weather = 1'b1;
        tick(6);
        // Short bad-weather glitch must be filtered out.
        weather = 1'b0; tick(3);
        weather = 1'b1; tick(3);
        // Two grants separated by a dead cycle, then both reservations time out.
        req = 1'b1; tick(3);
        req = 1'b0; tick(70);
        // Landing, clearance interrupted by a second occupancy, full clearance.
        occupied = 2'b01; tick(3);
        occupied = 2'b00; tick(8);
        occupied = 2'b01; tick(2);
        occupied = 2'b00; tick(20);
        // Emergency threshold boundary.
        passengers = 7'd60;  tick(3);
        passengers = 7'd59;  tick(3);
        passengers = 7'd127; tick(2);
        passengers = 7'd0;   tick(1);
        // Bad weather while runway 1 is occupied.
        occupied = 2'b10; tick(3);
        weather  = 1'b0;  tick(10);
        occupied = 2'b00; tick(25);
        // Reset in the middle of a clearance dwell.
        weather  = 1'b1;  tick(8);
        occupied = 2'b01; tick(2);
        occupied = 2'b00; tick(5);
        passengers = 7'd65;
        rst_n = 1'b0; tick(1);
        rst_n = 1'b1; tick(3);
        // Randomised traffic.
        for (int k = 0; k < 3000; k++) begin
            rst_n = ($urandom_range(0, 399) != 0);
            if ($urandom_range(0, 11) == 0) weather = ~weather;
            for (int i = 0; i < N; i++)
                if ($urandom_range(0, 19) == 0) occupied[i] = ~occupied[i];
            if ($urandom_range(0, 7) == 0) passengers = PAXW'($urandom_range(50, 70));
            req = ($urandom_range(0, 2) != 0);
            tick(1);
        end
        @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() == 0)
            passes++;
        else
            $display("FAIL drain got %0d pending expected 0", exp_q.size());
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
